// File: rtl/hand_score_calc.sv
// Serial blackjack hand scorer: snapshots both hands, walks one slot per cycle,
// then resolves soft aces and saturates the registered totals.
module hand_score_calc #(
  parameter int NUM_CARDS = 9,
  parameter int TARGET    = 21,
  parameter int SAT_MAX   = 31
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_CARDS-1:0][3:0]  player_card_values,
  input  logic [NUM_CARDS-1:0][3:0]  dealer_card_values,
  output logic [4:0]                 total_player_value,
  output logic [4:0]                 total_dealer_value,
  output logic                       player_soft,
  output logic                       dealer_soft,
  output logic                       bad_card,
  output logic                       scan_done
);

  localparam int IDX_W = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARDS - 1);
  localparam logic [7:0] TARGET_W = 8'(TARGET);
  localparam logic [6:0] SAT_W    = 7'(SAT_MAX);

  typedef enum logic [1:0] {LOAD, ACCUM, FINAL} state_t;

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic [NUM_CARDS-1:0][3:0]   player_snap;
  logic [NUM_CARDS-1:0][3:0]   dealer_snap;
  logic [6:0]                  acc_player;
  logic [6:0]                  acc_dealer;
  logic                        ace_player;
  logic                        ace_dealer;
  logic                        bad_seen;
  logic [3:0]                  player_code;
  logic [3:0]                  dealer_code;
  logic [5:0]                  res_player;
  logic [5:0]                  res_dealer;

  function automatic logic [6:0] card_worth(input logic [3:0] code);
    if (code >= 4'd14)      return 7'd0;
    else if (code >= 4'd11) return 7'd10;
    else                    return {3'b000, code};
  endfunction

  function automatic logic [4:0] sat_total(input logic [6:0] value);
    if (value > SAT_W) return SAT_W[4:0];
    else               return value[4:0];
  endfunction

  // Returns {soft, total}; only a single ace can ever be promoted to 11.
  function automatic logic [5:0] resolve(input logic [6:0] sum, input logic ace);
    logic [7:0] promoted;
    promoted = {1'b0, sum} + 8'd10;
    if (ace && (promoted <= TARGET_W)) return {1'b1, sat_total(promoted[6:0])};
    else                               return {1'b0, sat_total(sum)};
  endfunction

  always_comb begin
    player_code = player_snap[idx];
    dealer_code = dealer_snap[idx];
    res_player  = resolve(acc_player, ace_player);
    res_dealer  = resolve(acc_dealer, ace_dealer);
  end

  // Snapshot registers carry data only, so they are left out of reset.
  always_ff @(posedge clk) begin
    if (state == LOAD && en) begin
      player_snap <= player_card_values;
      dealer_snap <= dealer_card_values;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= LOAD;
      idx                <= '0;
      acc_player         <= '0;
      acc_dealer         <= '0;
      ace_player         <= 1'b0;
      ace_dealer         <= 1'b0;
      bad_seen           <= 1'b0;
      total_player_value <= '0;
      total_dealer_value <= '0;
      player_soft        <= 1'b0;
      dealer_soft        <= 1'b0;
      bad_card           <= 1'b0;
      scan_done          <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        LOAD: begin
          if (en) begin
            acc_player <= '0;
            acc_dealer <= '0;
            ace_player <= 1'b0;
            ace_dealer <= 1'b0;
            bad_seen   <= 1'b0;
            idx        <= '0;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          acc_player <= acc_player + card_worth(player_code);
          acc_dealer <= acc_dealer + card_worth(dealer_code);
          ace_player <= ace_player | (player_code == 4'd1);
          ace_dealer <= ace_dealer | (dealer_code == 4'd1);
          bad_seen   <= bad_seen | (player_code >= 4'd14) | (dealer_code >= 4'd14);
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= FINAL;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FINAL: begin
          total_player_value <= res_player[4:0];
          player_soft        <= res_player[5];
          total_dealer_value <= res_dealer[4:0];
          dealer_soft        <= res_dealer[5];
          bad_card           <= bad_seen;
          scan_done          <= 1'b1;
          state              <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_hand_score_calc.sv
// Bench for hand_score_calc: table of hands through a scoreboard, then
// hand-written sequences for scan period, mid-scan reset and enable drop.
module tb_hand_score_calc;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic [8:0][3:0] player_card_values = '0;
  logic [8:0][3:0] dealer_card_values = '0;
  logic [4:0]      total_player_value;
  logic [4:0]      total_dealer_value;
  logic            player_soft;
  logic            dealer_soft;
  logic            bad_card;
  logic            scan_done;

  hand_score_calc #(.NUM_CARDS(9), .TARGET(21), .SAT_MAX(31)) dut (
    .clk                (clk),
    .rst                (rst),
    .en                 (en),
    .player_card_values (player_card_values),
    .dealer_card_values (dealer_card_values),
    .total_player_value (total_player_value),
    .total_dealer_value (total_dealer_value),
    .player_soft        (player_soft),
    .dealer_soft        (dealer_soft),
    .bad_card           (bad_card),
    .scan_done          (scan_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] tp;
    logic [4:0] td;
    logic       sp;
    logic       sd;
    logic       bd;
  } exp_t;

  typedef struct {
    logic [8:0][3:0] p;
    logic [8:0][3:0] d;
    exp_t            e;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  bit   sb_on = 0;
  bit   prev_ok = 0;
  logic [12:0] prev_outs;
  exp_t sb_q[$];
  vec_t vecs[10];

  function automatic logic [8:0][3:0] hand(input int c0 = 0, input int c1 = 0,
      input int c2 = 0, input int c3 = 0, input int c4 = 0, input int c5 = 0,
      input int c6 = 0, input int c7 = 0, input int c8 = 0);
    logic [8:0][3:0] h;
    h[0] = c0[3:0]; h[1] = c1[3:0]; h[2] = c2[3:0];
    h[3] = c3[3:0]; h[4] = c4[3:0]; h[5] = c5[3:0];
    h[6] = c6[3:0]; h[7] = c7[3:0]; h[8] = c8[3:0];
    return h;
  endfunction

  function automatic vec_t mkv(input logic [8:0][3:0] p, input logic [8:0][3:0] d,
      input int tp, input int td, input bit sp, input bit sd, input bit bd);
    vec_t v;
    v.p = p;
    v.d = d;
    v.e.tp = tp[4:0];
    v.e.td = td[4:0];
    v.e.sp = sp;
    v.e.sd = sd;
    v.e.bd = bd;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no scan_done expected a pulse within 30 cycles", name);
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (scan_done) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tp"},   total_player_value, 0);
    chk({tag, "_td"},   total_dealer_value, 0);
    chk({tag, "_sp"},   player_soft, 0);
    chk({tag, "_sd"},   dealer_soft, 0);
    chk({tag, "_bad"},  bad_card, 0);
    chk({tag, "_done"}, scan_done, 0);
  endtask

  // Scoreboard: pops the expected record on every pulse, checks hold otherwise.
  always @(negedge clk) begin
    if (sb_on) begin
      if (scan_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_player_total", total_player_value, e.tp);
          chk("sb_dealer_total", total_dealer_value, e.td);
          chk("sb_player_soft",  player_soft, e.sp);
          chk("sb_dealer_soft",  dealer_soft, e.sd);
          chk("sb_bad_card",     bad_card, e.bd);
        end
      end else if (prev_ok) begin
        chk("hold_outputs", {total_player_value, total_dealer_value, player_soft,
                             dealer_soft, bad_card}, prev_outs);
      end
      prev_outs = {total_player_value, total_dealer_value, player_soft, dealer_soft, bad_card};
      prev_ok = 1;
    end
  end

  initial begin
    bit ok;
    int cyc;
    int pulses;

    vecs[0] = mkv(hand(10, 9), hand(10), 19, 10, 0, 0, 0);
    vecs[1] = mkv(hand(1, 13), hand(1), 21, 11, 1, 1, 0);
    vecs[2] = mkv(hand(1, 1, 9), hand(1, 1), 21, 12, 1, 1, 0);
    vecs[3] = mkv(hand(1, 9, 5), hand(10, 10, 5), 15, 25, 0, 0, 0);
    vecs[4] = mkv(hand(10, 10, 10, 10, 10, 10, 10, 10, 10),
                  hand(1, 1, 1, 1, 1, 1, 1, 1, 1), 31, 19, 0, 1, 0);
    vecs[5] = mkv(hand(0, 7, 0, 14, 3), hand(2), 10, 2, 0, 0, 1);
    vecs[6] = mkv(hand(5, 6), hand(11, 12, 1), 11, 21, 0, 0, 0);
    vecs[7] = mkv(hand(1, 10), hand(0, 0, 0, 0, 0, 0, 0, 0, 15), 21, 0, 1, 0, 1);
    vecs[8] = mkv(hand(10, 10, 1), hand(0, 0, 0, 0, 0, 0, 0, 0, 1), 21, 11, 0, 1, 0);
    vecs[9] = mkv(hand(10, 10, 10, 1), hand(6, 0, 5), 31, 11, 0, 0, 0);

    // Table phase
    @(negedge clk);
    do_reset();
    chk_zero("reset");
    prev_ok = 0;
    sb_on = 1;
    player_card_values = vecs[0].p;
    dealer_card_values = vecs[0].d;
    sb_q.push_back(vecs[0].e);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_done(ok);
      if (!ok) timeout_fail("table_scan");
      if (i < 9) begin
        player_card_values = vecs[i+1].p;
        dealer_card_values = vecs[i+1].d;
        sb_q.push_back(vecs[i+1].e);
      end
    end
    @(negedge clk);
    sb_on = 0;
    chk("sb_leftover", sb_q.size(), 0);

    // Scan period and input-change latency
    en = 1'b0;
    player_card_values = hand(5);
    dealer_card_values = hand(3);
    do_reset();
    chk_zero("reset2");
    en = 1'b1;
    cyc = 0;
    for (int k = 0; k < 34; k++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      chk($sformatf("period_c%0d", cyc), scan_done, (cyc % 11) == 0);
      if (cyc == 11) chk("first_total", total_player_value, 5);
      if (cyc == 12) player_card_values = hand(9);
      if (cyc == 22) chk("old_total_at_22", total_player_value, 5);
      if (cyc == 33) chk("new_total_at_33", total_player_value, 9);
    end

    // Reset at cycle 5 of a scan (scan started on edge 34)
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (scan_done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout_fail("rst_restart");
    chk("rst_restart_cycles", cyc, 11);
    chk("rst_restart_total", total_player_value, 9);
    chk("rst_restart_dealer", total_dealer_value, 3);

    // Enable drop mid-scan: scan finishes, input change during ACCUM ignored
    cyc = 0;
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 3) begin
        player_card_values = hand(4);
        en = 1'b0;
      end
      if (scan_done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout_fail("en_drop_scan");
    chk("en_drop_cycles", cyc, 11);
    chk("en_drop_total", total_player_value, 9);
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (scan_done) pulses++;
    end
    chk("idle_pulses", pulses, 0);
    chk("idle_total", total_player_value, 9);
    en = 1'b1;
    wait_done(ok);
    if (!ok) timeout_fail("re_enable");
    chk("re_enable_total", total_player_value, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
